// File: rtl/stretch_ctrl_if.sv
// stretch_ctrl_if -- signal bundle between the contrast-stretch controller
// and its surroundings.
//
// Groups the video timing/luma inputs, the register write bus and the
// coefficient handshake into one interface.
//   master : the side that produces video/config and accepts coefficients
//   slave  : the stretch_ctrl block itself
//
// Signals:
//   i_vsync    vertical sync; a falling edge marks the frame boundary
//   i_blank    high while the current pixel is active
//   i_y[7:0]   luma of the current pixel
//   cfg_we     register write strobe
//   cfg_addr   0=mode[1:0], 1=man_min, 2=man_max, 3=clear overrun
//   cfg_wdata  register write data
//   coef_valid new coefficient set offered
//   coef_ack   datapath accepts the offered set
//   coef_min   offset subtracted by the datapath
//   coef_gain  unsigned 8.8 multiplier
//   busy       controller is computing or publishing
//   overrun    sticky: a snapshot was dropped
interface stretch_ctrl_if;
  logic        i_vsync;
  logic        i_blank;
  logic [7:0]  i_y;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        coef_valid;
  logic        coef_ack;
  logic [7:0]  coef_min;
  logic [15:0] coef_gain;
  logic        busy;
  logic        overrun;

  modport master (
    output i_vsync, i_blank, i_y, cfg_we, cfg_addr, cfg_wdata, coef_ack,
    input  coef_valid, coef_min, coef_gain, busy, overrun
  );

  modport slave (
    input  i_vsync, i_blank, i_y, cfg_we, cfg_addr, cfg_wdata, coef_ack,
    output coef_valid, coef_min, coef_gain, busy, overrun
  );
endinterface

// File: rtl/stretch_ctrl.sv
// stretch_ctrl -- per-frame contrast-stretch coefficient controller.
//
// Tracks the luma range of each frame, and at every vsync falling edge
// snapshots a (min, max) pair chosen by the mode register, derives
// gain = floor(65280 / (max - min)) with a 16-cycle restoring divider,
// and offers (coef_min, coef_gain) to the datapath with a valid/ack
// handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    stretch_ctrl_if.slave (video inputs, config bus, coefficient
//          handshake, busy/overrun status)
//
// Parameter:
//   MIN_RANGE  auto-mode ranges narrower than this fall back to identity
//
// Build option:
//   STRETCH_SMOOTH_EN  when defined, auto-mode min/max are IIR-smoothed
//                      across frames before the range checks.
module stretch_ctrl #(
  parameter int MIN_RANGE = 16
) (
  input logic           clk,
  input logic           rst_n,
  stretch_ctrl_if.slave bus
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_DIV  = 2'd1;
  localparam logic [1:0] C_PUB  = 2'd2;

  localparam logic [8:0]  MIN_RANGE_W = 9'(MIN_RANGE);
  localparam logic [15:0] DIVIDEND    = 16'hFF00;

  logic [1:0]  vs_hist_q, vs_hist_d;
  logic [7:0]  acc_min_q, acc_min_d;
  logic [7:0]  acc_max_q, acc_max_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  man_min_q, man_min_d;
  logic [7:0]  man_max_q, man_max_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [7:0]  snap_min_q, snap_min_d;
  logic        coef_valid_q, coef_valid_d;
  logic [7:0]  coef_min_q, coef_min_d;
  logic [15:0] coef_gain_q, coef_gain_d;
  logic        overrun_q, overrun_d;

  logic        vs_neg;
  logic        snap_take;
  logic [7:0]  auto_min, auto_max;
  logic [7:0]  src_min, src_max, src_diff;
  logic        src_auto;
  logic [7:0]  new_min, new_range;
  logic [8:0]  div_tmp;
  logic        q_bit;
  logic [7:0]  rem_next;

  // Older history bit high, newer low: vsync just fell.
  assign vs_neg    = (vs_hist_q == 2'b10);
  assign snap_take = vs_neg && (state_q == C_IDLE);

`ifdef STRETCH_SMOOTH_EN
  logic [7:0]        sm_min_q, sm_min_d;
  logic [7:0]        sm_max_q, sm_max_d;
  logic              sm_valid_q, sm_valid_d;
  logic signed [8:0] sm_min_diff, sm_max_diff;
  logic signed [8:0] sm_min_step, sm_max_step;
  logic [7:0]        filt_min, filt_max;
  logic              unused_sm_sign;

  // The step never overshoots the target, so 8-bit modular addition of
  // the low step bits gives the exact filtered value.
  always_comb begin
    sm_min_diff = $signed({1'b0, acc_min_q}) - $signed({1'b0, sm_min_q});
    sm_max_diff = $signed({1'b0, acc_max_q}) - $signed({1'b0, sm_max_q});
    sm_min_step = sm_min_diff >>> 2;
    sm_max_step = sm_max_diff >>> 2;
    if (sm_valid_q) begin
      filt_min = sm_min_q + sm_min_step[7:0];
      filt_max = sm_max_q + sm_max_step[7:0];
    end else begin
      filt_min = acc_min_q;
      filt_max = acc_max_q;
    end
  end

  assign unused_sm_sign = sm_min_step[8] ^ sm_max_step[8];

  // A mode change restarts the filter so the next auto frame loads raw.
  always_comb begin
    sm_min_d   = sm_min_q;
    sm_max_d   = sm_max_q;
    sm_valid_d = sm_valid_q;
    if (snap_take && (mode_q == 2'd1)) begin
      sm_min_d   = filt_min;
      sm_max_d   = filt_max;
      sm_valid_d = 1'b1;
    end
    if (bus.cfg_we && (bus.cfg_addr == 2'd0) && (bus.cfg_wdata[1:0] != mode_q)) begin
      sm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_min_q   <= 8'd0;
      sm_max_q   <= 8'd0;
      sm_valid_q <= 1'b0;
    end else begin
      sm_min_q   <= sm_min_d;
      sm_max_q   <= sm_max_d;
      sm_valid_q <= sm_valid_d;
    end
  end

  assign auto_min = filt_min;
  assign auto_max = filt_max;
`else
  assign auto_min = acc_min_q;
  assign auto_max = acc_max_q;
`endif

  // Snapshot source selection and identity fallback.
  always_comb begin
    src_min  = 8'd0;
    src_max  = 8'd255;
    src_auto = 1'b0;
    case (mode_q)
      2'd1: begin
        src_min  = auto_min;
        src_max  = auto_max;
        src_auto = 1'b1;
      end
      2'd2: begin
        src_min = man_min_q;
        src_max = man_max_q;
      end
      default: begin
        src_min = 8'd0;
        src_max = 8'd255;
      end
    endcase
    src_diff  = src_max - src_min;
    new_min   = src_min;
    new_range = src_diff;
    if ((src_max <= src_min) || (src_auto && ({1'b0, src_diff} < MIN_RANGE_W))) begin
      new_min   = 8'd0;
      new_range = 8'd255;
    end
  end

  // One restoring-divide step. The remainder stays below the divisor, so
  // the subtraction result always fits back into 8 bits.
  always_comb begin
    div_tmp = {rem_q, div_q[15]};
    if (div_tmp >= {1'b0, divisor_q}) begin
      q_bit    = 1'b1;
      rem_next = div_tmp[7:0] - divisor_q;
    end else begin
      q_bit    = 1'b0;
      rem_next = div_tmp[7:0];
    end
  end

  // Frame statistics, configuration registers and overrun flag.
  always_comb begin
    vs_hist_d = {vs_hist_q[0], bus.i_vsync};

    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    if (vs_neg) begin
      if (bus.i_blank) begin
        acc_min_d = bus.i_y;
        acc_max_d = bus.i_y;
      end else begin
        acc_min_d = 8'd255;
        acc_max_d = 8'd0;
      end
    end else if (bus.i_blank) begin
      if (bus.i_y < acc_min_q) acc_min_d = bus.i_y;
      if (bus.i_y > acc_max_q) acc_max_d = bus.i_y;
    end

    mode_d    = mode_q;
    man_min_d = man_min_q;
    man_max_d = man_max_q;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0:    mode_d    = bus.cfg_wdata[1:0];
        2'd1:    man_min_d = bus.cfg_wdata;
        2'd2:    man_max_d = bus.cfg_wdata;
        default: ;
      endcase
    end

    // Clear first, so a simultaneous dropped snapshot sets it again.
    overrun_d = overrun_q;
    if (bus.cfg_we && (bus.cfg_addr == 2'd3)) overrun_d = 1'b0;
    if (vs_neg && (state_q != C_IDLE)) overrun_d = 1'b1;
  end

  // Snapshot / divide / publish sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    rem_d        = rem_q;
    divisor_d    = divisor_q;
    snap_min_d   = snap_min_q;
    coef_valid_d = coef_valid_q;
    coef_min_d   = coef_min_q;
    coef_gain_d  = coef_gain_q;
    case (state_q)
      C_IDLE: begin
        if (vs_neg) begin
          snap_min_d = new_min;
          divisor_d  = new_range;
          div_d      = DIVIDEND;
          rem_d      = 8'd0;
          cnt_d      = 4'd0;
          state_d    = C_DIV;
        end
      end
      C_DIV: begin
        div_d = {div_q[14:0], q_bit};
        rem_d = rem_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d      = C_PUB;
          coef_valid_d = 1'b1;
          coef_min_d   = snap_min_q;
          coef_gain_d  = {div_q[14:0], q_bit};
        end
      end
      C_PUB: begin
        if (bus.coef_ack) begin
          coef_valid_d = 1'b0;
          state_d      = C_IDLE;
        end
      end
      default: begin
        state_d      = C_IDLE;
        coef_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_hist_q    <= 2'b00;
      acc_min_q    <= 8'd255;
      acc_max_q    <= 8'd0;
      mode_q       <= 2'd0;
      man_min_q    <= 8'd0;
      man_max_q    <= 8'd255;
      state_q      <= C_IDLE;
      cnt_q        <= 4'd0;
      div_q        <= 16'd0;
      rem_q        <= 8'd0;
      divisor_q    <= 8'd255;
      snap_min_q   <= 8'd0;
      coef_valid_q <= 1'b0;
      coef_min_q   <= 8'd0;
      coef_gain_q  <= 16'd256;
      overrun_q    <= 1'b0;
    end else begin
      vs_hist_q    <= vs_hist_d;
      acc_min_q    <= acc_min_d;
      acc_max_q    <= acc_max_d;
      mode_q       <= mode_d;
      man_min_q    <= man_min_d;
      man_max_q    <= man_max_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      rem_q        <= rem_d;
      divisor_q    <= divisor_d;
      snap_min_q   <= snap_min_d;
      coef_valid_q <= coef_valid_d;
      coef_min_q   <= coef_min_d;
      coef_gain_q  <= coef_gain_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.coef_valid = coef_valid_q;
  assign bus.coef_min   = coef_min_q;
  assign bus.coef_gain  = coef_gain_q;
  assign bus.busy       = (state_q != C_IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_stretch_ctrl.sv
// tb_stretch_ctrl -- directed self-checking bench for stretch_ctrl.
//
// Drives vsync/blank/luma frames and config writes through stretch_ctrl_if
// and compares the published coefficients, handshake timing and status
// flags against hand-computed values.
module tb_stretch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  stretch_ctrl_if bus_if ();

  stretch_ctrl #(.MIN_RANGE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 unit after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_addr  = addr;
    bus_if.cfg_wdata = data;
    step();
    bus_if.cfg_we    = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] y);
    bus_if.i_blank = 1'b1;
    bus_if.i_y     = y;
    step();
    bus_if.i_blank = 1'b0;
  endtask

  // Returns during the cycle in which vs_neg is high; seed/y drive the
  // pixel presented in that same cycle.
  task automatic vsync_fall(input logic seed, input logic [7:0] y);
    bus_if.i_blank = 1'b0;
    bus_if.i_vsync = 1'b1;
    step();
    step();
    bus_if.i_vsync = 1'b0;
    step();
    bus_if.i_blank = seed;
    bus_if.i_y     = y;
  endtask

  // Called in the vs_neg cycle: valid must still be low 16 cycles later
  // and high at cycle 17 with the expected coefficients.
  task automatic wait_publish(input string tag, input logic [7:0] exp_min,
                              input logic [15:0] exp_gain);
    step();
    bus_if.i_blank = 1'b0;
    for (int i = 1; i < 16; i++) step();
    check_output({tag, "_valid_early"}, 16'(bus_if.coef_valid), 16'd0);
    step();
    check_output({tag, "_valid"}, 16'(bus_if.coef_valid), 16'd1);
    check_output({tag, "_min"}, 16'(bus_if.coef_min), 16'(exp_min));
    check_output({tag, "_gain"}, bus_if.coef_gain, exp_gain);
  endtask

  // With ack held high the offer is taken at once; valid/busy drop next.
  task automatic publish_acked(input string tag, input logic [7:0] exp_min,
                               input logic [15:0] exp_gain);
    vsync_fall(1'b0, 8'd0);
    wait_publish(tag, exp_min, exp_gain);
    step();
    check_output({tag, "_valid_drop"}, 16'(bus_if.coef_valid), 16'd0);
    check_output({tag, "_idle"}, 16'(bus_if.busy), 16'd0);
  endtask

  initial begin
    logic seen_valid;

    bus_if.i_vsync   = 1'b0;
    bus_if.i_blank   = 1'b0;
    bus_if.i_y       = 8'd0;
    bus_if.cfg_we    = 1'b0;
    bus_if.cfg_addr  = 2'd0;
    bus_if.cfg_wdata = 8'd0;
    bus_if.coef_ack  = 1'b0;

    // Reset state
    step();
    step();
    check_output("rst_valid", 16'(bus_if.coef_valid), 16'd0);
    check_output("rst_min", 16'(bus_if.coef_min), 16'd0);
    check_output("rst_gain", bus_if.coef_gain, 16'd256);
    check_output("rst_busy", 16'(bus_if.busy), 16'd0);
    check_output("rst_overrun", 16'(bus_if.overrun), 16'd0);
    rst_n = 1'b1;
    step();

    // Auto mode, ack tied high. First edge snapshots the empty reset
    // accumulators (max<=min) and so publishes identity.
    bus_if.coef_ack = 1'b1;
    cfg_write(2'd0, 8'd1);
    publish_acked("boot", 8'd0, 16'd256);

    pixel(8'd100); pixel(8'd50); pixel(8'd150); pixel(8'd75);
    publish_acked("auto", 8'd50, 16'd652);

    pixel(8'd80); pixel(8'd80); pixel(8'd80);
    publish_acked("flat", 8'd0, 16'd256);

    pixel(8'd100); pixel(8'd116);
    publish_acked("range16", 8'd100, 16'd4080);

    // Range 15 falls back; the pixel in the vs_neg cycle (30) seeds the
    // next frame and must not leak into this snapshot.
    pixel(8'd100); pixel(8'd115);
    vsync_fall(1'b1, 8'd30);
    wait_publish("range15", 8'd0, 16'd256);
    step();
    pixel(8'd200);
    publish_acked("seed", 8'd30, 16'd384);

    // Manual and bypass modes.
    cfg_write(2'd1, 8'd16);
    cfg_write(2'd2, 8'd235);
    cfg_write(2'd0, 8'd2);
    publish_acked("manual", 8'd16, 16'd298);
    cfg_write(2'd0, 8'd3);
    publish_acked("mode3", 8'd0, 16'd256);
    cfg_write(2'd1, 8'd10);
    cfg_write(2'd2, 8'd20);
    cfg_write(2'd0, 8'd2);
    publish_acked("man_narrow", 8'd10, 16'd6528);
    cfg_write(2'd1, 8'd200);
    cfg_write(2'd2, 8'd200);
    publish_acked("man_equal", 8'd0, 16'd256);
    cfg_write(2'd1, 8'd16);
    cfg_write(2'd2, 8'd235);
    publish_acked("manual2", 8'd16, 16'd298);
    cfg_write(2'd0, 8'd0);
    publish_acked("bypass", 8'd0, 16'd256);

    // Overrun: ack held low across further vsync edges.
    cfg_write(2'd0, 8'd2);
    bus_if.coef_ack = 1'b0;
    vsync_fall(1'b0, 8'd0);
    wait_publish("hold", 8'd16, 16'd298);
    step(); step(); step();
    check_output("hold_valid", 16'(bus_if.coef_valid), 16'd1);
    cfg_write(2'd1, 8'd0);
    vsync_fall(1'b0, 8'd0);
    step();
    check_output("ovr_set", 16'(bus_if.overrun), 16'd1);
    check_output("ovr_valid", 16'(bus_if.coef_valid), 16'd1);
    check_output("ovr_min", 16'(bus_if.coef_min), 16'd16);
    check_output("ovr_gain", bus_if.coef_gain, 16'd298);
    vsync_fall(1'b0, 8'd0);
    step();
    check_output("ovr2_busy", 16'(bus_if.busy), 16'd1);
    check_output("ovr2_gain", bus_if.coef_gain, 16'd298);
    cfg_write(2'd3, 8'd0);
    check_output("ovr_clear", 16'(bus_if.overrun), 16'd0);

    // Clear write in the same cycle as a dropped snapshot: set wins.
    vsync_fall(1'b0, 8'd0);
    cfg_write(2'd3, 8'd0);
    check_output("ovr_set_wins", 16'(bus_if.overrun), 16'd1);

    bus_if.coef_ack = 1'b1;
    step();
    check_output("ack_valid_drop", 16'(bus_if.coef_valid), 16'd0);
    check_output("ack_min_kept", 16'(bus_if.coef_min), 16'd16);
    check_output("ack_gain_kept", bus_if.coef_gain, 16'd298);
    cfg_write(2'd3, 8'd0);
    check_output("ovr_clear2", 16'(bus_if.overrun), 16'd0);

    // Reset asserted part-way through the divide.
    vsync_fall(1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step();
    check_output("div_busy", 16'(bus_if.busy), 16'd1);
    rst_n = 1'b0;
    step();
    check_output("mid_rst_valid", 16'(bus_if.coef_valid), 16'd0);
    check_output("mid_rst_min", 16'(bus_if.coef_min), 16'd0);
    check_output("mid_rst_gain", bus_if.coef_gain, 16'd256);
    check_output("mid_rst_busy", 16'(bus_if.busy), 16'd0);
    check_output("mid_rst_overrun", 16'(bus_if.overrun), 16'd0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus_if.coef_valid) seen_valid = 1'b1;
    end
    check_output("no_stale_valid", 16'(seen_valid), 16'd0);

    // Mode is back to bypass after reset.
    cfg_write(2'd1, 8'd40);
    publish_acked("post_reset", 8'd0, 16'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
